// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared bus constants and index-width helper for arbiter/demux.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int BUS_WIDTH = 32;

  // Index width for n sources; never zero, so single-source buses still carry an id.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter_if
// Brief    : N-requester valid/ready bundle plus merged output channel.
//            Packet-end markers exist only with BUS_ARB_LAST_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_rr_arbiter_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N     = 4
);

  localparam int IDW = idw(N);

  logic [N-1:0]       valid_i;
  logic [N*WIDTH-1:0] data_i;
  logic [N-1:0]       ready_o;
  logic               valid_o;
  logic [WIDTH-1:0]   data_o;
  logic [IDW-1:0]     id_o;
  logic               ready_i;
`ifdef BUS_ARB_LAST_EN
  logic [N-1:0]       last_i;
  logic               last_o;
`endif

`ifdef BUS_ARB_LAST_EN
  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, id_o, last_o
  );
  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, id_o, last_o
  );
`else
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, id_o
  );
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, id_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/bus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_pick
// Brief    : Combinational round-robin pick: first set request at or above
//            ptr_i, wrapping to the lowest set request below it.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter int N = 4
)(
  input  logic [N-1:0]       req_i,
  input  logic [idw(N)-1:0]  ptr_i,
  output logic [idw(N)-1:0]  pick_o,
  output logic               any_o
);

  localparam int IDW = idw(N);

  logic           hi_any, lo_any;
  logic [IDW-1:0] hi_pick, lo_pick;

  // Descending scan so the last hit written in each half is the lowest index.
  always_comb begin
    hi_any  = 1'b0;
    lo_any  = 1'b0;
    hi_pick = '0;
    lo_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        if (IDW'(k) >= ptr_i) begin
          hi_any  = 1'b1;
          hi_pick = IDW'(k);
        end else begin
          lo_any  = 1'b1;
          lo_pick = IDW'(k);
        end
      end
    end
  end

  assign any_o  = hi_any | lo_any;
  assign pick_o = hi_any ? hi_pick : lo_pick;

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter
// Brief    : Round-robin merge of N valid/ready sources into one registered
//            output stage tagged with the winner id. BUS_ARB_LAST_EN enables
//            packet-level locking on last_i.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N     = 4
)(
  input  logic            clk,
  input  logic            rst,
  bus_rr_arbiter_if.slave bus
);

  localparam int             IDW        = idw(N);
  localparam logic [IDW-1:0] C_LAST_IDX = IDW'(N - 1);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             w_load, w_xfer, w_rr_any, w_sel_any;
  logic [IDW-1:0]   w_rr_pick, w_sel_pick, w_nxt_ptr;
  logic [N-1:0]     w_grant;
  logic [WIDTH-1:0] w_sel_data;

`ifdef BUS_ARB_LAST_EN
  logic             lock_q, lock_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic             last_q, last_d;
  logic             w_sel_last;
`endif

  bus_rr_pick #(.N(N)) u_pick (
    .req_i  (bus.valid_i),
    .ptr_i  (ptr_q),
    .pick_o (w_rr_pick),
    .any_o  (w_rr_any)
  );

  always_comb begin
    w_sel_pick = w_rr_pick;
    w_sel_any  = w_rr_any;
`ifdef BUS_ARB_LAST_EN
    // Mid-packet the owner keeps the channel even while it stalls.
    if (lock_q) begin
      w_sel_pick = owner_q;
      w_sel_any  = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (owner_q == IDW'(k)) w_sel_any = bus.valid_i[k];
      end
    end
`endif
  end

  assign w_load = ~valid_q | bus.ready_i;

  generate
    for (genvar k = 0; k < N; k++) begin : g_grant
      assign w_grant[k] = w_load & w_sel_any & (w_sel_pick == IDW'(k));
    end
  endgenerate

  assign bus.ready_o = w_grant;
  assign w_xfer      = |w_grant;
  assign w_nxt_ptr   = (w_sel_pick == C_LAST_IDX) ? '0 : w_sel_pick + IDW'(1);

  always_comb begin
    w_sel_data = '0;
`ifdef BUS_ARB_LAST_EN
    w_sel_last = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin
      if (w_grant[k]) begin
        w_sel_data = bus.data_i[k*WIDTH +: WIDTH];
`ifdef BUS_ARB_LAST_EN
        w_sel_last = bus.last_i[k];
`endif
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (w_load) begin
      valid_d = w_xfer;
      if (w_xfer) begin
        data_d = w_sel_data;
        id_d   = w_sel_pick;
      end
    end
`ifdef BUS_ARB_LAST_EN
    lock_d  = lock_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (w_xfer) begin
      last_d = w_sel_last;
      if (w_sel_last) begin
        lock_d = 1'b0;
        ptr_d  = w_nxt_ptr;
      end else begin
        lock_d  = 1'b1;
        owner_d = w_sel_pick;
      end
    end
`else
    if (w_xfer) ptr_d = w_nxt_ptr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef BUS_ARB_LAST_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef BUS_ARB_LAST_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`endif
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.id_o    = id_q;
`ifdef BUS_ARB_LAST_EN
  assign bus.last_o  = last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rr_arbiter
// Brief    : Directed self-checking bench for bus_rr_arbiter (N=4, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rr_arbiter;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  bus_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", bus.valid_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %0h want 0", bus.data_o); end
    checks++; if (bus.id_o !== 2'd0) begin errors++; $display("FAIL rst_id got %0h want 0", bus.id_o); end
    rst = 1'b0;
    bus.valid_i = 4'b0100;
    bus.ready_i = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 4'b0100) begin errors++; $display("FAIL rst_first_ready got %b want 0100", bus.ready_o); end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL rst_beat_valid got %0h want 1", bus.valid_o); end
    checks++; if (bus.id_o !== 2'd2) begin errors++; $display("FAIL rst_beat_id got %0d want 2", bus.id_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL async_valid got %0h want 0", bus.valid_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL async_data got %0h want 0", bus.data_o); end
    checks++; if (bus.id_o !== 2'd0) begin errors++; $display("FAIL async_id got %0d want 0", bus.id_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.valid_i = 4'b0000;
    bus.ready_i = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b want 0000", bus.ready_o); end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %0h want 0", bus.valid_o); end
  endtask

  task automatic test_rotation();
    logic [1:0] eid;
    bus.valid_i = 4'b1111;
    #1;
    checks++; if (bus.ready_o !== 4'b0001) begin errors++; $display("FAIL rot_ready got %b want 0001", bus.ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      eid = 2'(i % 4);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d] got %0h want 1", i, bus.valid_o); end
      checks++; if (bus.id_o !== eid) begin errors++; $display("FAIL rot_id[%0d] got %0d want %0d", i, bus.id_o, eid); end
      checks++; if (bus.data_o !== (32'hA0 + 32'(eid))) begin errors++; $display("FAIL rot_data[%0d] got %0h want %0h", i, bus.data_o, 32'hA0 + 32'(eid)); end
    end
    bus.valid_i = 4'b0000;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL empty_valid got %0h want 0", bus.valid_o); end
    checks++; if (bus.id_o !== 2'd0) begin errors++; $display("FAIL empty_id_hold got %0d want 0", bus.id_o); end
    checks++; if (bus.data_o !== 32'hA0) begin errors++; $display("FAIL empty_data_hold got %0h want a0", bus.data_o); end
  endtask

  task automatic test_backpressure();
    bus.valid_i = 4'b1111;
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd1) begin errors++; $display("FAIL bp_first_id got %0d want 1", bus.id_o); end
    bus.ready_i = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready got %b want 0000", bus.ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h want 1", i, bus.valid_o); end
      checks++; if (bus.id_o !== 2'd1) begin errors++; $display("FAIL bp_id[%0d] got %0d want 1", i, bus.id_o); end
      checks++; if (bus.data_o !== 32'hA1) begin errors++; $display("FAIL bp_data[%0d] got %0h want a1", i, bus.data_o); end
      checks++; if (bus.ready_o !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready[%0d] got %b want 0000", i, bus.ready_o); end
    end
    bus.ready_i = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", bus.ready_o); end
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd2) begin errors++; $display("FAIL bp_next_id got %0d want 2", bus.id_o); end
    checks++; if (bus.data_o !== 32'hA2) begin errors++; $display("FAIL bp_next_data got %0h want a2", bus.data_o); end
    bus.valid_i = 4'b0000;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %0h want 0", bus.valid_o); end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_ids [5];
    exp_ids = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.valid_i = 4'b1010;
    #1;
    checks++; if (bus.ready_o !== 4'b0010) begin errors++; $display("FAIL sparse_ready got %b want 0010", bus.ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.id_o !== exp_ids[i]) begin errors++; $display("FAIL sparse_id[%0d] got %0d want %0d", i, bus.id_o, exp_ids[i]); end
      if (i == 2) bus.valid_i = 4'b1011;
    end
    bus.valid_i = 4'b0000;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL sparse_idle got %0h want 0", bus.valid_o); end
  endtask

`ifdef BUS_ARB_LAST_EN
  task automatic test_lock();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.last_i  = 4'b1111;
    bus.valid_i = 4'b0010;
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd1) begin errors++; $display("FAIL lock_pre_id got %0d want 1", bus.id_o); end
    bus.valid_i = 4'b0111;
    bus.last_i  = 4'b1011;
    #1;
    checks++; if (bus.ready_o !== 4'b0100) begin errors++; $display("FAIL lock_start_ready got %b want 0100", bus.ready_o); end
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd2) begin errors++; $display("FAIL lock_b1_id got %0d want 2", bus.id_o); end
    checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL lock_b1_last got %0h want 0", bus.last_o); end
    bus.valid_i = 4'b0011;
    #1;
    checks++; if (bus.ready_o !== 4'b0000) begin errors++; $display("FAIL lock_stall_ready got %b want 0000", bus.ready_o); end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL lock_bubble got %0h want 0", bus.valid_o); end
    bus.valid_i = 4'b0111;
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd2) begin errors++; $display("FAIL lock_b2_id got %0d want 2", bus.id_o); end
    checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL lock_b2_last got %0h want 0", bus.last_o); end
    bus.last_i = 4'b1111;
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd2) begin errors++; $display("FAIL lock_b3_id got %0d want 2", bus.id_o); end
    checks++; if (bus.last_o !== 1'b1) begin errors++; $display("FAIL lock_b3_last got %0h want 1", bus.last_o); end
    bus.valid_i = 4'b0011;
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd0) begin errors++; $display("FAIL lock_after0_id got %0d want 0", bus.id_o); end
    checks++; if (bus.last_o !== 1'b1) begin errors++; $display("FAIL lock_after0_last got %0h want 1", bus.last_o); end
    @(negedge clk);
    checks++; if (bus.id_o !== 2'd1) begin errors++; $display("FAIL lock_after1_id got %0d want 1", bus.id_o); end
    bus.valid_i = 4'b0000;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst         = 1'b1;
    bus.valid_i = '0;
    bus.ready_i = 1'b1;
    bus.data_i  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
`ifdef BUS_ARB_LAST_EN
    bus.last_i  = '1;
`endif
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse();
`ifdef BUS_ARB_LAST_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
